// File: rtl/alu_wb_pkg.sv
// Shared definitions for the ALU writeback stage: FSM states, dest/jump
// field bit positions and jump-field encodings.
package alu_wb_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } wb_state_e;

    // dest field bit positions
    localparam int unsigned DEST_A = 2;
    localparam int unsigned DEST_D = 1;
    localparam int unsigned DEST_M = 0;

    // jump field bit positions
    localparam int unsigned J_LT = 2;
    localparam int unsigned J_EQ = 1;
    localparam int unsigned J_GT = 0;

    localparam logic [2:0] JMP_NONE   = 3'b000;
    localparam logic [2:0] JMP_ALWAYS = 3'b111;

endpackage

// File: rtl/alu_writeback_jump_cond.sv
// Combinational jump-condition evaluator.
// Ports: value  - 16-bit result the condition is tested against
//        jump   - {jlt, jeq, jgt} condition mask
//        taken  - condition satisfied
//        zero   - value == 0
//        neg    - value bit 15
module jump_cond
    import alu_wb_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [2:0]        jump,
    output logic              taken,
    output logic              zero,
    output logic              neg
);

    logic w_zero;
    logic w_neg;

    assign w_zero = (value == '0);
    assign w_neg  = value[DATA_W-1];

    assign zero  = w_zero;
    assign neg   = w_neg;
    assign taken = (jump[J_LT] & w_neg)
                 | (jump[J_EQ] & w_zero)
                 | (jump[J_GT] & ~w_zero & ~w_neg);

endmodule

// File: rtl/alu_writeback.sv
// Writeback/retire stage behind the 16-bit ALU. Holds A, D, PC and the
// zr/ng flags, resolves conditional jumps and issues data-memory stores.
// Ports: clk, rst_n                      - clock, async active-low reset
//        in_valid / in_ready             - upstream handshake
//        is_ainst, imm, alu_out, dest, jump - decoded instruction + result
//        a_reg, d_reg, pc, zr, ng        - architectural state
//        retire                          - pulse per accepted instruction
//        mem_wr_valid/ready, mem_addr, mem_data - store port
module alu_writeback
    import alu_wb_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned IMM_W    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              is_ainst,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [2:0]        dest,
    input  logic [2:0]        jump,
    output logic [DATA_W-1:0] a_reg,
    output logic [DATA_W-1:0] d_reg,
    output logic [DATA_W-1:0] pc,
    output logic              zr,
    output logic              ng,
    output logic              retire,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data
);

    wb_state_e         r_state;
    logic [DATA_W-1:0] r_a_reg;
    logic [DATA_W-1:0] r_d_reg;
    logic [DATA_W-1:0] r_pc;
    logic              r_zr;
    logic              r_ng;
    logic              r_retire;
    logic              r_mem_wr_valid;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;

    logic              w_accept;
    logic              w_taken;
    logic              w_zero;
    logic              w_neg;
    logic [DATA_W-1:0] w_pc_inc;

    assign w_accept = in_valid & in_ready;
    assign w_pc_inc = DATA_W'(r_pc + DATA_W'(1));

    jump_cond u_jump_cond (
        .value (alu_out),
        .jump  (jump),
        .taken (w_taken),
        .zero  (w_zero),
        .neg   (w_neg)
    );

    // Stage FSM and architectural state; reads of r_a_reg see A before this
    // instruction's write, which is what jump targets and store addresses use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_a_reg        <= '0;
            r_d_reg        <= '0;
            r_pc           <= RESET_PC;
            r_zr           <= 1'b0;
            r_ng           <= 1'b0;
            r_retire       <= 1'b0;
            r_mem_wr_valid <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_data     <= '0;
        end else begin
            r_retire <= w_accept;
            case (r_state)
                RUN: begin
                    if (w_accept) begin
                        if (is_ainst) begin
                            r_a_reg <= DATA_W'(imm);
                            r_pc    <= w_pc_inc;
                        end else begin
                            r_zr <= w_zero;
                            r_ng <= w_neg;
                            if (dest[DEST_D]) r_d_reg <= alu_out;
                            if (dest[DEST_A]) r_a_reg <= alu_out;
                            r_pc <= w_taken ? r_a_reg : w_pc_inc;
                            if (dest[DEST_M]) begin
                                r_mem_addr     <= r_a_reg;
                                r_mem_data     <= alu_out;
                                r_mem_wr_valid <= 1'b1;
                                r_state        <= MEM_WAIT;
                            end
                        end
                    end
                end
                MEM_WAIT: begin
                    if (mem_wr_ready) begin
                        r_mem_wr_valid <= 1'b0;
                        r_state        <= RUN;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign in_ready     = (r_state == RUN);
    assign a_reg        = r_a_reg;
    assign d_reg        = r_d_reg;
    assign pc           = r_pc;
    assign zr           = r_zr;
    assign ng           = r_ng;
    assign retire       = r_retire;
    assign mem_wr_valid = r_mem_wr_valid;
    assign mem_addr     = r_mem_addr;
    assign mem_data     = r_mem_data;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback.
module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        is_ainst;
    logic [14:0] imm;
    logic [15:0] alu_out;
    logic [2:0]  dest;
    logic [2:0]  jump;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [15:0] pc;
    logic        zr;
    logic        ng;
    logic        retire;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;

    int n_checks = 0;
    int n_errors = 0;
    int low_cnt;

    alu_writeback #(.RESET_PC(16'h0000), .IMM_W(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .is_ainst     (is_ainst),
        .imm          (imm),
        .alu_out      (alu_out),
        .dest         (dest),
        .jump         (jump),
        .a_reg        (a_reg),
        .d_reg        (d_reg),
        .pc           (pc),
        .zr           (zr),
        .ng           (ng),
        .retire       (retire),
        .mem_wr_valid (mem_wr_valid),
        .mem_wr_ready (mem_wr_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Present one instruction for one edge, then sample #1 after the edge.
    task automatic step(input logic a, input logic [14:0] im, input logic [15:0] alu,
                        input logic [2:0] de, input logic [2:0] jp);
        is_ainst = a;
        imm      = im;
        alu_out  = alu;
        dest     = de;
        jump     = jp;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        is_ainst     = 1'b0;
        imm          = '0;
        alu_out      = '0;
        dest         = '0;
        jump         = '0;
        mem_wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a", 32'(a_reg), 32'h0);
        chk("rst_d", 32'(d_reg), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_flags", {30'b0, zr, ng}, 32'h0);
        chk("rst_retire", 32'(retire), 32'h0);
        chk("rst_memv", 32'(mem_wr_valid), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;
        idle();

        // A-instruction
        step(1'b1, 15'h1234, 16'h0, 3'b111, 3'b111);
        chk("ai_a", 32'(a_reg), 32'h1234);
        chk("ai_pc", 32'(pc), 32'h0001);
        chk("ai_retire", 32'(retire), 32'h1);
        chk("ai_flags", {30'b0, zr, ng}, 32'h0);
        chk("ai_memv", 32'(mem_wr_valid), 32'h0);
        idle();
        chk("idle_retire", 32'(retire), 32'h0);
        chk("idle_pc", 32'(pc), 32'h0001);

        // jeq taken with dest=A: pc gets old A
        step(1'b1, 15'h0010, 16'h0, 3'b000, 3'b000);
        chk("a10_pc", 32'(pc), 32'h0002);
        step(1'b0, 15'h0, 16'h0000, 3'b100, 3'b010);
        chk("jeq_pc", 32'(pc), 32'h0010);
        chk("jeq_a", 32'(a_reg), 32'h0000);
        chk("jeq_flags", {30'b0, zr, ng}, 32'h2);

        // jlt|jgt on negative, then jlt on positive, jgt on positive, none on zero
        step(1'b1, 15'h0050, 16'h0, 3'b000, 3'b000);
        chk("a50_pc", 32'(pc), 32'h0011);
        step(1'b0, 15'h0, 16'h8001, 3'b000, 3'b101);
        chk("jneg_pc", 32'(pc), 32'h0050);
        chk("jneg_ng", 32'(ng), 32'h1);
        chk("jneg_zr", 32'(zr), 32'h0);
        step(1'b0, 15'h0, 16'h0001, 3'b000, 3'b100);
        chk("jlt_nt_pc", 32'(pc), 32'h0051);
        chk("jlt_nt_ng", 32'(ng), 32'h0);
        step(1'b0, 15'h0, 16'h0001, 3'b000, 3'b001);
        chk("jgt_pc", 32'(pc), 32'h0050);
        step(1'b0, 15'h0, 16'h0000, 3'b000, 3'b000);
        chk("jnone_pc", 32'(pc), 32'h0051);
        chk("jnone_zr", 32'(zr), 32'h1);
        chk("jnone_d", 32'(d_reg), 32'h0);

        // Store with delayed memory ready
        step(1'b1, 15'h0200, 16'h0, 3'b000, 3'b000);
        low_cnt = 0;
        step(1'b0, 15'h0, 16'hBEEF, 3'b011, 3'b000);
        chk("st_d", 32'(d_reg), 32'hBEEF);
        chk("st_a", 32'(a_reg), 32'h0200);
        chk("st_pc", 32'(pc), 32'h0053);
        chk("st_memv", 32'(mem_wr_valid), 32'h1);
        // upstream holds an instruction that must be ignored while stalled
        is_ainst = 1'b1;
        imm      = 15'h7777;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!in_ready) low_cnt++;
            chk("st_wait_addr", 32'(mem_addr), 32'h0200);
            chk("st_wait_data", 32'(mem_data), 32'hBEEF);
            chk("st_wait_valid", 32'(mem_wr_valid), 32'h1);
            idle();
            chk("st_wait_retire", 32'(retire), 32'h0);
            chk("st_wait_a", 32'(a_reg), 32'h0200);
        end
        in_valid     = 1'b0;
        mem_wr_ready = 1'b1;
        if (!in_ready) low_cnt++;
        chk("st_hs_valid", 32'(mem_wr_valid), 32'h1);
        idle();
        mem_wr_ready = 1'b0;
        chk("st_low_cycles", 32'(low_cnt), 32'd4);
        chk("st_done_valid", 32'(mem_wr_valid), 32'h0);
        chk("st_done_ready", 32'(in_ready), 32'h1);

        // PC wrap
        step(1'b1, 15'h0000, 16'h0, 3'b000, 3'b000);
        chk("w0_pc", 32'(pc), 32'h0054);
        step(1'b0, 15'h0, 16'hFFFF, 3'b100, 3'b000);
        chk("wA_a", 32'(a_reg), 32'hFFFF);
        chk("wA_pc", 32'(pc), 32'h0055);
        step(1'b0, 15'h0, 16'h0000, 3'b000, 3'b111);
        chk("jmp_pc", 32'(pc), 32'hFFFF);
        step(1'b0, 15'h0, 16'h0005, 3'b000, 3'b000);
        chk("wrap_pc", 32'(pc), 32'h0000);

        // Async reset during MEM_WAIT
        step(1'b1, 15'h0300, 16'h0, 3'b000, 3'b000);
        step(1'b0, 15'h0, 16'h1234, 3'b011, 3'b000);
        chk("rw_memv", 32'(mem_wr_valid), 32'h1);
        chk("rw_ready", 32'(in_ready), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_memv", 32'(mem_wr_valid), 32'h0);
        chk("ar_a", 32'(a_reg), 32'h0);
        chk("ar_d", 32'(d_reg), 32'h0);
        chk("ar_pc", 32'(pc), 32'h0);
        chk("ar_mem", {mem_addr, mem_data}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        chk("ar_rel_ready", 32'(in_ready), 32'h1);
        chk("ar_rel_memv", 32'(mem_wr_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Writeback/retire stage directly downstream of the 16-bit ALU; consumes the ALU result plus decoded destination and jump fields.
- Holds the architectural A, D and PC registers and the zr/ng status flags.
- Evaluates the conditional jump and issues data-memory stores through a valid/ready port.
- Stalls upstream with in_ready while a store is outstanding.

Parameters:
- RESET_PC, 16'h0000, value loaded into PC on reset.
- IMM_W, 15, width of A-instruction immediate; A is loaded as {1'b0, imm}.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream instruction/result valid.
- in_ready  output  1  stage can accept; high only in RUN.
- is_ainst  input  1  1 = A-instruction (load immediate), 0 = compute instruction.
- imm  input  IMM_W  immediate for A-instruction.
- alu_out  input  16  ALU result for compute instruction.
- dest  input  3  [2]=A, [1]=D, [0]=M write enables.
- jump  input  3  [2]=jlt, [1]=jeq, [0]=jgt.
- a_reg  output  16  A register.
- d_reg  output  16  D register.
- pc  output  16  program counter.
- zr  output  1  registered flag: last compute result == 0.
- ng  output  1  registered flag: last compute result bit15.
- retire  output  1  one-cycle pulse, registered, for each accepted instruction.
- mem_wr_valid  output  1  store request valid.
- mem_wr_ready  input  1  memory accepts store.
- mem_addr  output  16  store address.
- mem_data  output  16  store data.

Behaviour:
- Reset (async, rst_n=0): a_reg=0, d_reg=0, pc=RESET_PC, zr=0, ng=0, retire=0, mem_wr_valid=0, mem_addr=0, mem_data=0, state=RUN. Reset during MEM_WAIT discards the pending store.
- States: RUN, MEM_WAIT. in_ready = (state==RUN).
- Accept = in_valid & in_ready. All register updates occur on the clock edge of accept; outputs visible the following cycle (latency 1).
- A-instruction accept: a_reg <= {1'b0, imm}; pc <= pc+1; d_reg, zr and ng unchanged; dest and jump ignored; no store.
- Compute accept:
  - zr <= (alu_out==0); ng <= alu_out[15].
  - dest[1]: d_reg <= alu_out.
  - dest[2]: a_reg <= alu_out.
- Jump condition, from this instruction's alu_out: taken = (jump[2]&neg) | (jump[1]&zero) | (jump[0]&~zero&~neg). jump=3'b111 is unconditional; 3'b000 never jumps.
- PC update: pc <= taken ? a_old : pc+1, where a_old is A before this instruction's write. This holds even when dest[2] is also set.
- PC wrap: pc+1 wraps 16'hFFFF -> 16'h0000.
- Store (dest[0]=1): mem_addr <= a_old; mem_data <= alu_out; mem_wr_valid <= 1; state -> MEM_WAIT. Architectural registers and PC retire on the same edge; they do not wait for the store.
- MEM_WAIT: mem_wr_valid, mem_addr and mem_data are held stable. On mem_wr_ready=1, mem_wr_valid <= 0 and state -> RUN; in_ready rises the cycle after the handshake (no bypass).
- retire <= accept every cycle.
- in_valid is ignored while in_ready=0. Upstream holds its data; this stage does not buffer it.

Decomposition:
- Shared package alu_wb_pkg: state enum {RUN, MEM_WAIT}; dest bit indices DEST_A=2, DEST_D=1, DEST_M=0; jump bit indices J_LT=2, J_EQ=1, J_GT=0; constants JMP_NONE=3'b000, JMP_ALWAYS=3'b111.
- One combinational sub-module, jump_cond: inputs value[15:0] and jump[2:0]; outputs taken, zero, neg. Reusable by a future branch predictor.

Test Plan:
- Reset then A-instruction imm=15'h1234: next cycle a_reg=16'h1234, pc=1, retire=1, zr=0, ng=0.
- A=16'h0010, compute alu_out=16'h0000, dest=3'b100, jump=3'b010: pc=16'h0010 (old A), a_reg=0, zr=1, ng=0.
- Compute alu_out=16'h8001, jump=3'b101: taken, pc=A. Then alu_out=16'h0001, jump=3'b100: not taken, pc+1. ng reads 1 then 0.
- Compute alu_out=16'hBEEF, dest=3'b011, A=16'h0200, mem_wr_ready held low 3 cycles: d_reg=16'hBEEF, mem_addr=16'h0200, mem_data=16'hBEEF stable, in_ready=0 for 4 cycles; after handshake mem_wr_valid=0 and in_ready=1 next cycle.
- pc=16'hFFFF with non-jumping instruction: pc=16'h0000.
- Assert rst_n=0 asynchronously mid-MEM_WAIT: mem_wr_valid drops immediately, all registers at reset values, in_ready=1 after release.
